// File: rtl/oled_spi_pkg.sv
// rtl/oled_spi_pkg.sv - shared constants and FSM encoding for the SSD1306 SPI writer
// Word layout on spi_data: [9]=skip, [8]=DC (0 command, 1 data), [7:0]=byte.
package oled_spi_pkg;

  localparam logic [1:0] TAG_CMD  = 2'b00;
  localparam logic [1:0] TAG_DATA = 2'b01;
  localparam int         SKIP_BIT = 9;
  localparam int         DC_BIT   = 8;

  // Half-periods per byte: 8 rising + 8 falling SCLK edges.
  localparam int         HALF_PERIODS = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_FINISH,
    ST_SKIP,
    ST_WAIT_LOW
  } state_e;

endpackage

// File: rtl/spi_half_tick.sv
// rtl/spi_half_tick.sv - SCLK half-period divider emitting one-cycle ticks
// Ports:
//   clk_i   in  system clock
//   rst_i   in  synchronous active-high reset
//   clr_i   in  restart the half-period count (accept edge)
//   en_i    in  count while high
//   tick_o  out high on the cycle that ends a half-period of CLK_DIV cycles
module spi_half_tick #(
  parameter int CLK_DIV = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == CW'(CLK_DIV - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (tick_o) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/oled_spi_writer.sv
// rtl/oled_spi_writer.sv - byte-level 4-wire SPI transmitter for the SSD1306 panel
// Ports:
//   clk_1m           in  system clock, rising edge
//   rst              in  synchronous active-high reset
//   spi_write_start  in  level request, held until spi_write_done is seen
//   spi_data[9:0]    in  {skip, dc, byte}
//   spi_write_done   out one-cycle completion pulse
//   spi_busy         out high from accept through the done cycle
//   oled_cs_n        out chip select, active low
//   oled_sclk        out SPI mode-0 clock
//   oled_mosi        out serial data, MSB first
//   oled_dc          out data/command select
module oled_spi_writer
  import oled_spi_pkg::*;
#(
  parameter int CLK_DIV = 1
) (
  input  logic       clk_1m,
  input  logic       rst,
  input  logic       spi_write_start,
  input  logic [9:0] spi_data,
  output logic       spi_write_done,
  output logic       spi_busy,
  output logic       oled_cs_n,
  output logic       oled_sclk,
  output logic       oled_mosi,
  output logic       oled_dc
);

  state_e     state_q, state_d;
  logic [7:0] shreg_q, shreg_d;
  logic [3:0] hcnt_q, hcnt_d;
  logic       cs_n_q, cs_n_d;
  logic       sclk_q, sclk_d;
  logic       mosi_q, mosi_d;
  logic       dc_q, dc_d;
  logic       done_q, done_d;
  logic       busy_q, busy_d;
  logic       accept;
  logic       shift_en;
  logic       tick;

  assign accept   = (state_q == ST_IDLE) && spi_write_start;
  assign shift_en = (state_q == ST_SHIFT);

  spi_half_tick #(
    .CLK_DIV(CLK_DIV)
  ) u_half_tick (
    .clk_i (clk_1m),
    .rst_i (rst),
    .clr_i (accept),
    .en_i  (shift_en),
    .tick_o(tick)
  );

  always_ff @(posedge clk_1m) begin
    if (rst) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      hcnt_q  <= '0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      dc_q    <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      hcnt_q  <= hcnt_d;
      cs_n_q  <= cs_n_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      dc_q    <= dc_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:     if (spi_write_start) state_d = spi_data[SKIP_BIT] ? ST_SKIP : ST_SHIFT;
      ST_SHIFT:    if (tick && hcnt_q == 4'(HALF_PERIODS - 1)) state_d = ST_FINISH;
      ST_FINISH:   state_d = ST_WAIT_LOW;
      ST_SKIP:     state_d = ST_WAIT_LOW;
      // The sequencer drops start one cycle after done; waiting here keeps the
      // still-high request from being taken as a second word.
      ST_WAIT_LOW: if (!spi_write_start) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    shreg_d = shreg_q;
    hcnt_d  = hcnt_q;
    cs_n_d  = cs_n_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    dc_d    = dc_q;
    done_d  = 1'b0;
    busy_d  = busy_q;
    unique case (state_q)
      ST_IDLE: begin
        if (spi_write_start) begin
          busy_d  = 1'b1;
          hcnt_d  = '0;
          shreg_d = spi_data[7:0];
          if (!spi_data[SKIP_BIT]) begin
            cs_n_d = 1'b0;
            sclk_d = 1'b0;
            dc_d   = spi_data[DC_BIT];
            mosi_d = spi_data[7];
          end
        end
      end
      ST_SHIFT: begin
        if (tick) begin
          sclk_d = ~sclk_q;
          hcnt_d = hcnt_q + 4'd1;
          // Odd hcnt_q means this tick is a falling edge; present the next bit,
          // except on the final falling edge which just parks SCLK low.
          if (hcnt_q[0] && hcnt_q != 4'(HALF_PERIODS - 1)) begin
            mosi_d  = shreg_q[6];
            shreg_d = {shreg_q[6:0], 1'b0};
          end
        end
      end
      ST_FINISH, ST_SKIP: begin
        cs_n_d = 1'b1;
        done_d = 1'b1;
      end
      ST_WAIT_LOW: busy_d = 1'b0;
      default: ;
    endcase
  end

  assign spi_write_done = done_q;
  assign spi_busy       = busy_q;
  assign oled_cs_n      = cs_n_q;
  assign oled_sclk      = sclk_q;
  assign oled_mosi      = mosi_q;
  assign oled_dc        = dc_q;

endmodule

// File: tb/tb_oled_spi_writer.sv
// tb/tb_oled_spi_writer.sv - scoreboard bench for oled_spi_writer at CLK_DIV 1 and 3
module tb_oled_spi_writer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst_w   [2];
  logic       start_w [2];
  logic [9:0] data_w  [2];
  logic       done_w  [2];
  logic       busy_w  [2];
  logic       cs_w    [2];
  logic       sclk_w  [2];
  logic       mosi_w  [2];
  logic       dc_w    [2];

  oled_spi_writer #(.CLK_DIV(1)) dut0 (
    .clk_1m(clk), .rst(rst_w[0]), .spi_write_start(start_w[0]), .spi_data(data_w[0]),
    .spi_write_done(done_w[0]), .spi_busy(busy_w[0]), .oled_cs_n(cs_w[0]),
    .oled_sclk(sclk_w[0]), .oled_mosi(mosi_w[0]), .oled_dc(dc_w[0])
  );

  oled_spi_writer #(.CLK_DIV(3)) dut1 (
    .clk_1m(clk), .rst(rst_w[1]), .spi_write_start(start_w[1]), .spi_data(data_w[1]),
    .spi_write_done(done_w[1]), .spi_busy(busy_w[1]), .oled_cs_n(cs_w[1]),
    .oled_sclk(sclk_w[1]), .oled_mosi(mosi_w[1]), .oled_dc(dc_w[1])
  );

  int checks = 0;
  int errors = 0;
  int bit_q[$];
  int cs_q[$];
  int busy_q[$];
  int done_q[$];
  bit mon_en = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int div_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  // Monitor: sample on the falling edge, pop expectations as events appear.
  logic p_sclk [2];
  logic p_cs   [2];
  logic p_done [2];
  logic p_busy [2];
  int   cs_fall   [2];
  int   cs_rise   [2];
  int   busy_rise [2];
  int   last_tog  [2];
  bit   had_frame [2] = '{0, 0};

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (mon_en) begin
        if (p_cs[d] && !cs_w[d]) begin
          if (had_frame[d]) chk("cs_gap_ge2", int'((cyc - cs_rise[d]) >= 2), 1);
          cs_fall[d]  = cyc;
          last_tog[d] = cyc;
        end
        if (!p_cs[d] && (sclk_w[d] != p_sclk[d])) begin
          chk("sclk_half_period", cyc - last_tog[d], div_of(d));
          last_tog[d] = cyc;
        end
        if (!p_sclk[d] && sclk_w[d]) begin
          if (bit_q.size() == 0) chk("unexpected_sclk_rise", 1, 0);
          else begin
            chk("dc_mosi_at_rise", int'({dc_w[d], mosi_w[d]}), bit_q.pop_front());
            chk("cs_low_at_rise", int'(cs_w[d]), 0);
          end
        end
        if (!p_cs[d] && cs_w[d]) begin
          cs_rise[d]   = cyc;
          had_frame[d] = 1;
          if (cs_q.size() == 0) chk("unexpected_cs_frame", 1, 0);
          else chk("cs_low_cycles", cyc - cs_fall[d], cs_q.pop_front());
        end
        if (done_w[d]) begin
          chk("done_one_cycle", int'(p_done[d]), 0);
          chk("busy_with_done", int'(busy_w[d]), 1);
          if (done_q.size() == 0) chk("unexpected_done", 1, 0);
          else chk("done_cycle", cyc, done_q.pop_front());
        end
        if (p_done[d] && !done_w[d]) chk("busy_after_done", int'(busy_w[d]), 0);
        if (!p_busy[d] && busy_w[d]) busy_rise[d] = cyc;
        if (p_busy[d] && !busy_w[d]) begin
          if (busy_q.size() == 0) chk("unexpected_busy", 1, 0);
          else chk("busy_cycles", cyc - busy_rise[d], busy_q.pop_front());
        end
      end
      p_sclk[d] = sclk_w[d];
      p_cs[d]   = cs_w[d];
      p_done[d] = done_w[d];
      p_busy[d] = busy_w[d];
    end
  end

  // Sequencer model. mode 0: normal handshake; 1: start dropped at t=4 and
  // data changed at t=5; 2: reset at t=6. Called at posedge+#1 with DUT idle.
  task automatic send(input int d, input logic [9:0] w, input int mode,
                      input logic [7:0] exp_bits, input logic exp_dc, input int exp_lat);
    int acc;
    bit seen;
    start_w[d] = 1'b1;
    data_w[d]  = w;
    acc = cyc + 1;
    if (mode == 2) begin
      for (int i = 7; i >= 5; i--) bit_q.push_back(int'({exp_dc, exp_bits[i]}));
      cs_q.push_back(6);
      busy_q.push_back(6);
    end else begin
      if (!w[9]) begin
        for (int i = 7; i >= 0; i--) bit_q.push_back(int'({exp_dc, exp_bits[i]}));
        cs_q.push_back(exp_lat);
      end
      busy_q.push_back(exp_lat + 1);
      done_q.push_back(acc + exp_lat);
    end
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clk); #1;
      if (mode == 1 && cyc == acc + 4) start_w[d] = 1'b0;
      if (mode == 1 && cyc == acc + 5) data_w[d] = 10'h300;
      if (mode == 2 && cyc == acc + 5) begin
        rst_w[d]   = 1'b1;
        start_w[d] = 1'b0;
      end
      if (mode == 2 && cyc == acc + 6) begin
        rst_w[d] = 1'b0;
        chk("abort_cs_n", int'(cs_w[d]), 1);
        chk("abort_sclk", int'(sclk_w[d]), 0);
        chk("abort_busy", int'(busy_w[d]), 0);
        chk("abort_done", int'(done_w[d]), 0);
        seen = 1;
      end
      if (mode != 2 && done_w[d]) seen = 1;
    end
    if (!seen) chk("handshake_timeout", 0, 1);
    if (mode != 2) begin
      @(posedge clk); #1;
      start_w[d] = 1'b0;
    end
    @(posedge clk); #1;
    if (mode == 1) begin
      repeat (3) @(posedge clk);
      #1;
      chk("no_resend_busy", int'(busy_w[d]), 0);
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst_w[d]   = 1'b1;
      start_w[d] = 1'b0;
      data_w[d]  = 10'h0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("reset_cs_n", int'(cs_w[d]), 1);
      chk("reset_sclk", int'(sclk_w[d]), 0);
      chk("reset_mosi", int'(mosi_w[d]), 0);
      chk("reset_dc",   int'(dc_w[d]), 0);
      chk("reset_done", int'(done_w[d]), 0);
      chk("reset_busy", int'(busy_w[d]), 0);
      rst_w[d] = 1'b0;
    end
    @(posedge clk); #1;
    mon_en = 1;

    send(0, {2'b00, 8'hAE}, 0, 8'b1010_1110, 1'b0, 17);
    send(0, {2'b01, 8'h5A}, 0, 8'b0101_1010, 1'b1, 17);
    send(0, {2'b01, 8'hFF}, 0, 8'b1111_1111, 1'b1, 17);
    send(0, {2'b11, 8'h00}, 0, 8'h00,        1'b1, 1);
    send(1, {2'b00, 8'h81}, 0, 8'b1000_0001, 1'b0, 49);
    send(0, {2'b01, 8'hC3}, 2, 8'b1100_0011, 1'b1, 17);
    send(0, {2'b00, 8'h3C}, 0, 8'b0011_1100, 1'b0, 17);
    send(0, {2'b01, 8'h96}, 1, 8'b1001_0110, 1'b1, 17);

    repeat (10) @(posedge clk);
    #1;
    chk("bits_left",  bit_q.size(), 0);
    chk("cs_left",    cs_q.size(), 0);
    chk("busy_left",  busy_q.size(), 0);
    chk("done_left",  done_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
